cordic_phase_seq: RTL and testbench
===================================

// Module: cordic_phase_seq
// PURPOSE
//  Front-end/back-end sequencer for the iterative cordic core. Accepts a full-circle unsigned
//  phase word over a valid/ready handshake, folds it into quadrant + residual, converts the
//  residual to a Q1.WD_EXT radian angle in [0, pi/2), runs one cordic conversion, then
//  unfolds sin/cos by quadrant and presents them on a valid/ready output register.
// PARAMETERS
//  WD_EXT   8    cordic external fraction bits; angle/sin/cos are WD_EXT+2 bits signed
//  PHASE_W  10   input phase width; full scale 2^PHASE_W == 2*pi
//  TIMEOUT  255  max cycles in WAIT before flagging an error
// PORTS
//  i_clk          in   1          clock
//  i_rst          in   1          reset, asynchronous, active-high
//  i_phase        in   PHASE_W    unsigned phase, 0..2^PHASE_W-1 maps to [0, 2*pi)
//  i_valid        in   1          phase valid
//  o_ready        out  1          sequencer can accept a phase
//  o_cordic_angle out  WD_EXT+2   angle to cordic i_angle, signed Q1.WD_EXT radians
//  o_cordic_start out  1          one-cycle start pulse to cordic i_start
//  i_cordic_sin   in   WD_EXT+2   cordic o_sin
//  i_cordic_cos   in   WD_EXT+2   cordic o_cos
//  i_cordic_done  in   1          cordic o_done (level, cleared by cordic on accepted start)
//  o_sin, o_cos   out  WD_EXT+2   quadrant-corrected results, signed Q1.WD_EXT
//  o_valid        out  1          result valid
//  i_ready        in   1          downstream accepts result
//  o_err          out  1          sticky: WAIT exceeded TIMEOUT cycles
// BEHAVIOUR
//  Reset (async): state IDLE; o_ready=1, o_cordic_start=0, o_valid=0, o_err=0,
//   o_sin=o_cos=o_cordic_angle=0, quad=0, timeout counter=0. Reset mid-conversion aborts
//   cleanly; cordic shares i_rst (its sync reset clears it on the next edge).
//  States: IDLE -> START -> WAIT -> OUT -> IDLE.
//  IDLE: o_ready=1. On i_valid: quad<=i_phase[PHASE_W-1:PHASE_W-2];
//   res=i_phase[PHASE_W-3:0]; o_cordic_angle<=(res*HALF_PI_Q)>>(PHASE_W-2), unsigned
//   product width PHASE_W-2+WD_EXT+2, truncating; -> START.
//  START: o_cordic_start=1 for exactly this cycle; o_ready=0; -> WAIT, counter<=0.
//  WAIT: stale done is impossible (cordic clears done on the start edge). On i_cordic_done:
//   capture with unfold, -> OUT. Else counter++; at counter==TIMEOUT set o_err, -> IDLE
//   (no result produced).
//  Unfold (s=i_cordic_sin, c=i_cordic_cos): q0: sin=s, cos=c; q1: sin=c, cos=-s;
//   q2: sin=-s, cos=-c; q3: sin=-c, cos=s. Negation saturates: -(-2^(WD_EXT+1)) ->
//   2^(WD_EXT+1)-1.
//  OUT: o_valid=1, o_sin/o_cos held stable until i_valid&&... i_ready; on i_ready:
//   o_valid<=0, -> IDLE. i_ready ignored when o_valid=0.
//  No overlap: one phase in flight; o_ready=1 only in IDLE. Phase accepted in same cycle as
//   result release is not possible (OUT->IDLE first); throughput = 1 per (iters+4) cycles.
//  Latency i_valid accept -> o_valid: 1 (START) + cordic iterations (max_i+1) + 1 capture.
//  Boundary: phase 0 -> quad0, angle 0; phase 2^PHASE_W-1 -> quad3, angle just below pi/2.
//  o_err cleared only by reset.
// STRUCTURE
//  Shared package (cordic_params): WD_EXT, HALF_PI_Q = round(pi/2*2^WD_EXT) (402 for 8),
//   state encoding localparams, saturating-negate function.
//  No sub-module; the cordic core is instantiated alongside by the parent, not inside.
// TESTING (WD_EXT=8, PHASE_W=10, real cordic core attached; tolerance +/-3 LSB)
//  phase 0x000 -> o_sin~0, o_cos~256; angle driven 0
//  phase 0x080 -> angle 201; o_sin~181, o_cos~181
//  phase 0x100 / 0x200 / 0x300 -> (256,0) / (0,-256) / (-256,0) for (sin,cos)
//  i_ready held 0 for 10 cycles in OUT -> o_valid, o_sin, o_cos stable; i_valid ignored
//  force i_cordic_done=0 -> o_err=1 after TIMEOUT+1 WAIT cycles, back to IDLE, o_ready=1
//  assert i_rst during WAIT -> all outputs 0 immediately; next phase converts correctly

Source files
------------

// File: rtl/cordic_phase_seq_pkg.sv
// Shared constants, state encoding and helpers for the cordic phase sequencer.
// Angles and sin/cos results are signed Q1.WD_EXT words, ANG_W bits wide.
package cordic_phase_seq_pkg;

  localparam int WD_EXT = 8;
  localparam int ANG_W  = WD_EXT + 2;

  // round(pi/2 * 2^WD_EXT); evaluates to 402 for WD_EXT = 8
  localparam logic [ANG_W-1:0] HALF_PI_Q =
    ANG_W'($rtoi(1.5707963267948966 * (2.0 ** WD_EXT) + 0.5));

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // Two's-complement negate that maps the most negative code to the most positive one
  function automatic logic signed [ANG_W-1:0] sat_neg(input logic signed [ANG_W-1:0] v);
    logic signed [ANG_W-1:0] r;
    if (v == {1'b1, {(ANG_W-1){1'b0}}}) begin
      r = {1'b0, {(ANG_W-1){1'b1}}};
    end else begin
      r = -v;
    end
    return r;
  endfunction

endpackage

// File: rtl/cordic_phase_seq_if.sv
// Phase-in / result-out valid-ready bundle of the cordic phase sequencer.
// master = upstream producer plus downstream consumer; slave = the sequencer.
interface cordic_phase_seq_if #(
  parameter int PHASE_W = 10,
  parameter int DW      = 10
);
  logic [PHASE_W-1:0]   i_phase;
  logic                 i_valid;
  logic                 o_ready;
  logic signed [DW-1:0] o_sin;
  logic signed [DW-1:0] o_cos;
  logic                 o_valid;
  logic                 i_ready;

  modport master (
    output i_phase, i_valid, i_ready,
    input  o_ready, o_sin, o_cos, o_valid
  );

  modport slave (
    input  i_phase, i_valid, i_ready,
    output o_ready, o_sin, o_cos, o_valid
  );
endinterface

// File: rtl/cordic_phase_seq.sv
// Folds a full-circle phase into quadrant + first-quadrant angle, runs one cordic
// conversion, then unfolds sin/cos by quadrant onto a valid/ready result register.
module cordic_phase_seq
  import cordic_phase_seq_pkg::*;
#(
  parameter int PHASE_W = 10,
  parameter int TIMEOUT = 255
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  cordic_phase_seq_if.slave       bus,
  output logic signed [ANG_W-1:0] o_cordic_angle,
  output logic                    o_cordic_start,
  input  logic signed [ANG_W-1:0] i_cordic_sin,
  input  logic signed [ANG_W-1:0] i_cordic_cos,
  input  logic                    i_cordic_done,
  output logic                    o_err
);

  localparam int RES_W  = PHASE_W - 2;
  localparam int PROD_W = RES_W + ANG_W;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  state_t                  state_r;
  logic [1:0]              quad_r;
  logic [CNT_W-1:0]        cnt_r;
  logic                    ready_r;
  logic                    start_r;
  logic                    valid_r;
  logic                    err_r;
  logic signed [ANG_W-1:0] angle_r;
  logic signed [ANG_W-1:0] sin_r;
  logic signed [ANG_W-1:0] cos_r;

  logic [RES_W-1:0]        res_s;
  logic [PROD_W-1:0]       prod_s;
  logic [ANG_W-1:0]        angle_s;
  logic signed [ANG_W-1:0] unf_sin_s;
  logic signed [ANG_W-1:0] unf_cos_s;

  // Residual phase scaled to radians; truncation keeps the angle strictly below pi/2
  always_comb begin
    res_s   = bus.i_phase[RES_W-1:0];
    prod_s  = PROD_W'(res_s) * PROD_W'(HALF_PI_Q);
    angle_s = ANG_W'(prod_s >> RES_W);
  end

  // Quadrant unfold of the first-quadrant cordic result
  always_comb begin
    unf_sin_s = i_cordic_sin;
    unf_cos_s = i_cordic_cos;
    case (quad_r)
      2'd0: begin unf_sin_s = i_cordic_sin;          unf_cos_s = i_cordic_cos;          end
      2'd1: begin unf_sin_s = i_cordic_cos;          unf_cos_s = sat_neg(i_cordic_sin); end
      2'd2: begin unf_sin_s = sat_neg(i_cordic_sin); unf_cos_s = sat_neg(i_cordic_cos); end
      2'd3: begin unf_sin_s = sat_neg(i_cordic_cos); unf_cos_s = i_cordic_sin;          end
      default: begin unf_sin_s = i_cordic_sin;       unf_cos_s = i_cordic_cos;          end
    endcase
  end

  // Sequencer FSM with all outputs registered
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
      quad_r  <= 2'd0;
      cnt_r   <= '0;
      ready_r <= 1'b1;
      start_r <= 1'b0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      angle_r <= '0;
      sin_r   <= '0;
      cos_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.i_valid) begin
            quad_r  <= bus.i_phase[PHASE_W-1 -: 2];
            angle_r <= angle_s;
            ready_r <= 1'b0;
            start_r <= 1'b1;
            state_r <= ST_START;
          end
        end
        ST_START: begin
          start_r <= 1'b0;
          cnt_r   <= '0;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_cordic_done) begin
            sin_r   <= unf_sin_s;
            cos_r   <= unf_cos_s;
            valid_r <= 1'b1;
            state_r <= ST_OUT;
          end else if (cnt_r == CNT_W'(TIMEOUT)) begin
            err_r   <= 1'b1;
            ready_r <= 1'b1;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_OUT: begin
          if (bus.i_ready) begin
            valid_r <= 1'b0;
            ready_r <= 1'b1;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          start_r <= 1'b0;
          valid_r <= 1'b0;
          ready_r <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_ready     = ready_r;
  assign bus.o_valid     = valid_r;
  assign bus.o_sin       = sin_r;
  assign bus.o_cos       = cos_r;
  assign o_cordic_angle  = angle_r;
  assign o_cordic_start  = start_r;
  assign o_err           = err_r;

endmodule

// File: tb/tb_cordic_phase_seq.sv
// Directed bench for cordic_phase_seq with a behavioural cordic core alongside
// (10 iterations, rounded real sin/cos, optional output override and hang).
module tb_cordic_phase_seq;
  import cordic_phase_seq_pkg::*;

  localparam int PHASE_W = 10;
  localparam int TIMEOUT = 255;
  localparam int ITERS   = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cordic_phase_seq_if #(.PHASE_W(PHASE_W), .DW(ANG_W)) bus ();

  logic signed [ANG_W-1:0] c_angle, c_sin, c_cos;
  logic                    c_start, c_done, err;

  cordic_phase_seq #(.PHASE_W(PHASE_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .bus            (bus),
    .o_cordic_angle (c_angle),
    .o_cordic_start (c_start),
    .i_cordic_sin   (c_sin),
    .i_cordic_cos   (c_cos),
    .i_cordic_done  (c_done),
    .o_err          (err)
  );

  logic                    hang, ovr, mbusy;
  logic signed [ANG_W-1:0] ovr_sin, ovr_cos;
  int                      mcnt;

  function automatic logic signed [ANG_W-1:0] qsin(input logic signed [ANG_W-1:0] a);
    real r;
    r = $sin($itor(a) / 256.0) * 256.0;
    return ANG_W'(int'(r));
  endfunction

  function automatic logic signed [ANG_W-1:0] qcos(input logic signed [ANG_W-1:0] a);
    real r;
    r = $cos($itor(a) / 256.0) * 256.0;
    return ANG_W'(int'(r));
  endfunction

  // Behavioural cordic: sync reset, done cleared on start, result after ITERS cycles
  always @(posedge clk) begin
    if (rst) begin
      c_done <= 1'b0; mbusy <= 1'b0; mcnt <= 0; c_sin <= '0; c_cos <= '0;
    end else if (c_start) begin
      c_done <= 1'b0; mbusy <= 1'b1; mcnt <= ITERS - 1;
    end else if (mbusy) begin
      if (mcnt == 0) begin
        mbusy  <= 1'b0;
        c_done <= !hang;
        c_sin  <= ovr ? ovr_sin : qsin(c_angle);
        c_cos  <= ovr ? ovr_cos : qcos(c_angle);
      end else begin
        mcnt <= mcnt - 1;
      end
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    logic ok;
    ok = (obs >= exp - 3) && (obs <= exp + 3);
    tests++;
    assert (ok === 1'b1) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d +/-3", tag, obs, exp);
    end
  endtask

  // Present a phase and sample #1 after the edge that accepts it
  task automatic send(input logic [PHASE_W-1:0] p);
    @(negedge clk);
    bus.i_phase = p;
    bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (bus.o_valid !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_ready = 1'b0;
  endtask

  task automatic convert(input string tag, input logic [PHASE_W-1:0] p,
                         input int exp_sin, input int exp_cos);
    int lat;
    send(p);
    wait_valid(lat);
    chk({tag, "_lat"}, lat, 12);
    chk_tol({tag, "_sin"}, bus.o_sin, exp_sin);
    chk_tol({tag, "_cos"}, bus.o_cos, exp_cos);
    release_out();
    chk({tag, "_rel"}, {bus.o_valid, bus.o_ready}, 2'b01);
  endtask

  initial begin
    int lat;
    logic stable, no_start;
    logic signed [ANG_W-1:0] hs, hc;

    rst = 1'b1; bus.i_valid = 1'b0; bus.i_ready = 1'b0; bus.i_phase = '0;
    hang = 1'b0; ovr = 1'b0; ovr_sin = '0; ovr_cos = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", bus.o_ready, 1);
    chk("rst_outs", {bus.o_valid, err, c_start}, 0);
    chk("rst_data", {bus.o_sin, bus.o_cos, c_angle}, 0);
    @(negedge clk); rst = 1'b0;

    // Phase 0: angle 0, start pulse right after acceptance
    send(10'h000);
    chk("p000_angle", c_angle, 0);
    chk("p000_start", {c_start, bus.o_ready}, 2'b10);
    @(posedge clk); #1;
    chk("p000_start_off", c_start, 0);
    wait_valid(lat);
    chk("p000_lat", lat, 11);
    chk_tol("p000_sin", bus.o_sin, 0);
    chk_tol("p000_cos", bus.o_cos, 256);
    release_out();

    send(10'h080);
    chk("p080_angle", c_angle, 201);
    wait_valid(lat);
    chk_tol("p080_sin", bus.o_sin, 181);
    chk_tol("p080_cos", bus.o_cos, 181);
    release_out();

    convert("p100", 10'h100, 256, 0);
    convert("p200", 10'h200, 0, -256);
    convert("p300", 10'h300, -256, 0);

    // Top boundary: quadrant 3, angle floor(255*402/256) = 400
    send(10'h3FF);
    chk("p3ff_angle", c_angle, 400);
    wait_valid(lat);
    chk_tol("p3ff_sin", bus.o_sin, -2);
    chk_tol("p3ff_cos", bus.o_cos, 256);
    release_out();

    // Saturating negate in quadrant 2 and quadrant 1
    ovr = 1'b1; ovr_sin = -10'sd512; ovr_cos = 10'sd100;
    send(10'h200);
    wait_valid(lat);
    chk("sat_q2_sin", bus.o_sin, 511);
    chk("sat_q2_cos", bus.o_cos, -100);
    release_out();
    send(10'h100);
    wait_valid(lat);
    chk("sat_q1_sin", bus.o_sin, 100);
    chk("sat_q1_cos", bus.o_cos, 511);
    release_out();
    ovr = 1'b0;

    // Back-pressure: hold i_ready low with a competing phase offered
    send(10'h080);
    wait_valid(lat);
    hs = bus.o_sin; hc = bus.o_cos;
    stable = 1'b1; no_start = 1'b1;
    @(negedge clk); bus.i_phase = 10'h300; bus.i_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.o_valid !== 1'b1 || bus.o_sin !== hs || bus.o_cos !== hc || bus.o_ready !== 1'b0)
        stable = 1'b0;
      if (c_start !== 1'b0) no_start = 1'b0;
    end
    bus.i_valid = 1'b0;
    chk("hold_stable", stable, 1);
    chk("hold_no_start", no_start, 1);
    chk_tol("hold_sin", hs, 181);
    release_out();
    convert("after_hold", 10'h300, -256, 0);

    // Timeout: 1 START edge + TIMEOUT+1 WAIT edges
    hang = 1'b1;
    send(10'h100);
    lat = 0;
    while (err !== 1'b1 && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("tmo_edges", lat, TIMEOUT + 2);
    chk("tmo_state", {bus.o_ready, bus.o_valid}, 2'b10);
    hang = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("tmo_no_result", bus.o_valid, 0);
    convert("after_tmo", 10'h000, 0, 256);
    chk("err_sticky", err, 1);

    // Asynchronous reset mid-WAIT
    send(10'h200);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_ready", bus.o_ready, 1);
    chk("arst_outs", {bus.o_valid, err, c_start}, 0);
    chk("arst_data", {bus.o_sin, bus.o_cos, c_angle}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    convert("after_rst", 10'h080, 181, 181);
    chk("after_rst_err", err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
